// File: rtl/serial_add_ctrl.sv
// Serial 2-bit-slice adder: a+b+cin computed over WIDTH/2 RUN cycles, LSB slice first.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSL = WIDTH / 2;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             chain_q, chain_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic [CW:0]      idx;
    logic [1:0]       x, y;
    logic             s_lo, c_lo, s_hi, c_hi;

    // Bit-serial split of the 2-bit slice: c_lo is the carry into the slice MSB.
    always_comb begin
        idx          = {cnt_q, 1'b0};
        x            = a_q[idx +: 2];
        y            = b_q[idx +: 2];
        {c_lo, s_lo} = {1'b0, x[0]} + {1'b0, y[0]} + {1'b0, chain_q};
        {c_hi, s_hi} = {1'b0, x[1]} + {1'b0, y[1]} + {1'b0, c_lo};
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    chain_d = cin;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[idx +: 2] = {s_hi, s_lo};
                chain_d          = c_hi;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Result registers load from the just-completed working value.
                    sum_d   = work_d;
                    carry_d = c_hi;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = c_lo ^ c_hi;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            chain_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl at WIDTH=8.
// Checks ovf as well when built with SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({busy, done, sum, carry} !== 11'b0) begin
            $display("FAIL reset_state: busy=%b done=%b sum=%h carry=%b, want 0 0 00 0",
                     busy, done, sum, carry);
            n_err++;
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            $display("FAIL reset_ovf: got %b want 0", ovf);
            n_err++;
        end
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
            n_err++;
        end
    endtask

    task automatic test_basic();
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
                $display("FAIL basic_run_c%0d: busy=%b done=%b sum=%h carry=%b want 1 0 00 0",
                         i, busy, done, sum, carry);
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b1 || sum !== 8'h00 || carry !== 1'b1) begin
            $display("FAIL basic_done_c5: busy=%b done=%b sum=%h carry=%b want 0 1 00 1",
                     busy, done, sum, carry);
            n_err++;
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || carry !== 1'b1) begin
            $display("FAIL basic_after: busy=%b done=%b sum=%h carry=%b want 0 0 00 1",
                     busy, done, sum, carry);
            n_err++;
        end
    endtask

    task automatic test_mixed();
        int cyc;
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 5 || sum !== 8'h8E || carry !== 1'b0) begin
            $display("FAIL mixed: cyc=%0d sum=%h carry=%b want 5 8e 0", cyc, sum, carry);
            n_err++;
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ovf !== 1'b1) begin
            $display("FAIL mixed_ovf: got %b want 1", ovf);
            n_err++;
        end
`endif
        tick();
    endtask

    task automatic test_ignore_start();
        int dones;
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a     = 8'h00;
        b     = 8'h00;
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i >= 4) start = 1'b0;
            if (done === 1'b1) dones++;
            tick();
        end
        n_vec++;
        if (dones !== 1) begin
            $display("FAIL ignore_done_count: got %0d want 1", dones);
            n_err++;
        end
        n_vec++;
        if (sum !== 8'h00 || carry !== 1'b1) begin
            $display("FAIL ignore_result: sum=%h carry=%b want 00 1", sum, carry);
            n_err++;
        end
    endtask

    task automatic test_abort();
        int dones;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry !== 1'b0) begin
            $display("FAIL abort_state: busy=%b done=%b sum=%h carry=%b want 0 0 00 0",
                     busy, done, sum, carry);
            n_err++;
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        n_vec++;
        if (dones !== 0) begin
            $display("FAIL abort_no_done: active cycles=%0d want 0", dones);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int         seen;
        int         dcyc[2];
        logic [8:0] res[2];
        logic       ov[2];
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a    = 8'h80;
        b    = 8'h80;
        seen = 0;
        for (int c = 1; c <= 20 && seen < 2; c++) begin
            if (done === 1'b1) begin
                dcyc[seen] = c;
                res[seen]  = {carry, sum};
`ifdef SERIAL_ADD_OVF_EN
                ov[seen]   = ovf;
`else
                ov[seen]   = 1'b0;
`endif
                seen++;
                if (seen == 2) start = 1'b0;
            end
            tick();
        end
        n_vec++;
        if (seen !== 2) begin
            $display("FAIL b2b_count: got %0d dones want 2", seen);
            n_err++;
        end else begin
            n_vec++;
            if (dcyc[0] !== 5 || dcyc[1] !== 11) begin
                $display("FAIL b2b_timing: done at %0d,%0d want 5,11", dcyc[0], dcyc[1]);
                n_err++;
            end
            n_vec++;
            if (res[0] !== 9'h002 || res[1] !== 9'h100) begin
                $display("FAIL b2b_results: got %h,%h want 002,100", res[0], res[1]);
                n_err++;
            end
`ifdef SERIAL_ADD_OVF_EN
            n_vec++;
            if (ov[0] !== 1'b0 || ov[1] !== 1'b1) begin
                $display("FAIL b2b_ovf: got %b,%b want 0,1", ov[0], ov[1]);
                n_err++;
            end
`endif
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        int         cyc;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rc;
        int         bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            rc    = 1'($urandom_range(0, 1));
            a     = ra;
            b     = rb;
            cin   = rc;
            start = 1'b1;
            tick();
            start = 1'b0;
            exp   = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            cyc   = 1;
            while (done !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            n_vec++;
            if (cyc !== 5 || {carry, sum} !== exp) begin
                if (bad < 10)
                    $display("FAIL random_%0d: a=%h b=%h cin=%b cyc=%0d got %h want %h",
                             n, ra, rb, rc, cyc, {carry, sum}, exp);
                bad++;
                n_err++;
            end
`ifdef SERIAL_ADD_OVF_EN
            n_vec++;
            if (ovf !== ((ra[7] == rb[7]) && (exp[7] != ra[7]))) begin
                if (bad < 10)
                    $display("FAIL random_ovf_%0d: a=%h b=%h cin=%b got %b", n, ra, rb, rc, ovf);
                bad++;
                n_err++;
            end
`endif
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_basic();
        test_mixed();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
